// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Opcode/funct encodings, ALU and memory-size codes, and the
//            control bundle carried down the pipeline.
// Revision : 1.0
// ============================================================================
package ctrl_pkg;

    localparam int c_alu_w = 5;
    localparam int c_reg_w = 5;

    localparam logic [5:0] c_op_rtype  = 6'b000000;
    localparam logic [5:0] c_op_regimm = 6'b000001;
    localparam logic [5:0] c_op_j      = 6'b000010;
    localparam logic [5:0] c_op_jal    = 6'b000011;
    localparam logic [5:0] c_op_beq    = 6'b000100;
    localparam logic [5:0] c_op_bne    = 6'b000101;
    localparam logic [5:0] c_op_blez   = 6'b000110;
    localparam logic [5:0] c_op_bgtz   = 6'b000111;
    localparam logic [5:0] c_op_addi   = 6'b001000;
    localparam logic [5:0] c_op_addiu  = 6'b001001;
    localparam logic [5:0] c_op_slti   = 6'b001010;
    localparam logic [5:0] c_op_andi   = 6'b001100;
    localparam logic [5:0] c_op_ori    = 6'b001101;
    localparam logic [5:0] c_op_xori   = 6'b001110;
    localparam logic [5:0] c_op_mul    = 6'b011100;
    localparam logic [5:0] c_op_lb     = 6'b100000;
    localparam logic [5:0] c_op_lh     = 6'b100001;
    localparam logic [5:0] c_op_lw     = 6'b100011;
    localparam logic [5:0] c_op_sb     = 6'b101000;
    localparam logic [5:0] c_op_sh     = 6'b101001;
    localparam logic [5:0] c_op_sw     = 6'b101011;

    localparam logic [5:0] c_fn_sll  = 6'b000000;
    localparam logic [5:0] c_fn_srl  = 6'b000010;
    localparam logic [5:0] c_fn_jr   = 6'b001000;
    localparam logic [5:0] c_fn_add  = 6'b100000;
    localparam logic [5:0] c_fn_addu = 6'b100001;
    localparam logic [5:0] c_fn_sub  = 6'b100010;
    localparam logic [5:0] c_fn_and  = 6'b100100;
    localparam logic [5:0] c_fn_or   = 6'b100101;
    localparam logic [5:0] c_fn_xor  = 6'b100110;
    localparam logic [5:0] c_fn_nor  = 6'b100111;
    localparam logic [5:0] c_fn_slt  = 6'b101010;
    localparam logic [5:0] c_fn_mul  = 6'b000010;

    localparam logic [c_alu_w-1:0] c_alu_add  = 5'b00001;
    localparam logic [c_alu_w-1:0] c_alu_sub  = 5'b00010;
    localparam logic [c_alu_w-1:0] c_alu_mul  = 5'b00011;
    localparam logic [c_alu_w-1:0] c_alu_sll  = 5'b00100;
    localparam logic [c_alu_w-1:0] c_alu_srl  = 5'b00101;
    localparam logic [c_alu_w-1:0] c_alu_and  = 5'b00110;
    localparam logic [c_alu_w-1:0] c_alu_or   = 5'b00111;
    localparam logic [c_alu_w-1:0] c_alu_xor  = 5'b01000;
    localparam logic [c_alu_w-1:0] c_alu_bgez = 5'b01011;
    localparam logic [c_alu_w-1:0] c_alu_beq  = 5'b01100;
    localparam logic [c_alu_w-1:0] c_alu_nor  = 5'b01101;
    localparam logic [c_alu_w-1:0] c_alu_slt  = 5'b01110;
    localparam logic [c_alu_w-1:0] c_alu_bne  = 5'b01111;
    localparam logic [c_alu_w-1:0] c_alu_bgtz = 5'b10000;
    localparam logic [c_alu_w-1:0] c_alu_blez = 5'b10001;
    localparam logic [c_alu_w-1:0] c_alu_bltz = 5'b10010;

    localparam logic [1:0] c_sz_none = 2'b00;
    localparam logic [1:0] c_sz_word = 2'b01;
    localparam logic [1:0] c_sz_half = 2'b10;
    localparam logic [1:0] c_sz_byte = 2'b11;

    typedef struct packed {
        logic               alusrc;
        logic               regdst;
        logic               shift;
        logic [c_alu_w-1:0] aluctrl;
        logic [1:0]         memwrite;
        logic [1:0]         memread;
        logic               regwrite;
        logic               memtoreg;
        logic               jal;
        logic [c_reg_w-1:0] writereg;
    } ctrl_t;

    localparam ctrl_t c_bubble = '0;

endpackage
`default_nettype wire

// File: rtl/pipelined_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_controller_if
// Purpose  : Datapath <-> controller signal bundle; master is the datapath.
// Revision : 1.0
// ============================================================================
interface pipelined_controller_if #(
    parameter int ALU_CTRL_W = 5,
    parameter int REG_ADDR_W = 5
) ();
    logic [31:0]           Instruction;
    logic                  BranchTaken;
    logic                  PCWrite;
    logic                  IFIDWrite;
    logic                  IFIDFlush;
    logic                  Jump;
    logic                  Jr;
    logic                  EX_ALUSrc;
    logic                  EX_RegDst;
    logic                  EX_ShiftControl;
    logic [ALU_CTRL_W-1:0] EX_ALUControl;
    logic [1:0]            MEM_MemWrite;
    logic [1:0]            MEM_MemRead;
    logic                  WB_RegWrite;
    logic                  WB_MemToReg;
    logic                  WB_Jal;
    logic [REG_ADDR_W-1:0] WB_WriteReg;

    modport master (
        output Instruction, BranchTaken,
        input  PCWrite, IFIDWrite, IFIDFlush, Jump, Jr,
        input  EX_ALUSrc, EX_RegDst, EX_ShiftControl, EX_ALUControl,
        input  MEM_MemWrite, MEM_MemRead,
        input  WB_RegWrite, WB_MemToReg, WB_Jal, WB_WriteReg
    );

    modport slave (
        input  Instruction, BranchTaken,
        output PCWrite, IFIDWrite, IFIDFlush, Jump, Jr,
        output EX_ALUSrc, EX_RegDst, EX_ShiftControl, EX_ALUControl,
        output MEM_MemWrite, MEM_MemRead,
        output WB_RegWrite, WB_MemToReg, WB_Jal, WB_WriteReg
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Purpose  : Combinational ID-stage decode of one instruction into a bundle.
// Revision : 1.0
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl,
    output logic        o_jump,
    output logic        o_jr,
    output logic        o_uses_rt,
    output logic        o_is_mul
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic       w_unused;

    assign w_op     = i_instr[31:26];
    assign w_rt     = i_instr[20:16];
    assign w_rd     = i_instr[15:11];
    assign w_fn     = i_instr[5:0];
    assign w_unused = ^{i_instr[25:21], i_instr[10:6]};

    always_comb begin
        o_ctrl    = c_bubble;
        o_jump    = 1'b0;
        o_jr      = 1'b0;
        o_uses_rt = 1'b0;
        o_is_mul  = 1'b0;
        case (w_op)
            c_op_rtype: begin
                o_uses_rt       = 1'b1;
                o_ctrl.regdst   = 1'b1;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.writereg = w_rd;
                case (w_fn)
                    c_fn_add, c_fn_addu: o_ctrl.aluctrl = c_alu_add;
                    c_fn_sub:            o_ctrl.aluctrl = c_alu_sub;
                    c_fn_and:            o_ctrl.aluctrl = c_alu_and;
                    c_fn_or:             o_ctrl.aluctrl = c_alu_or;
                    c_fn_xor:            o_ctrl.aluctrl = c_alu_xor;
                    c_fn_nor:            o_ctrl.aluctrl = c_alu_nor;
                    c_fn_slt:            o_ctrl.aluctrl = c_alu_slt;
                    c_fn_sll: begin
                        o_ctrl.aluctrl = c_alu_sll;
                        o_ctrl.shift   = 1'b1;
                    end
                    c_fn_srl: begin
                        o_ctrl.aluctrl = c_alu_srl;
                        o_ctrl.shift   = 1'b1;
                    end
                    c_fn_jr: begin
                        o_ctrl = c_bubble;
                        o_jr   = 1'b1;
                    end
                    default: o_ctrl = c_bubble;
                endcase
            end
            c_op_mul: begin
                o_uses_rt = 1'b1;
                if (w_fn == c_fn_mul) begin
                    o_is_mul        = 1'b1;
                    o_ctrl.regdst   = 1'b1;
                    o_ctrl.regwrite = 1'b1;
                    o_ctrl.writereg = w_rd;
                    o_ctrl.aluctrl  = c_alu_mul;
                end
            end
            c_op_addi, c_op_addiu, c_op_slti, c_op_andi, c_op_ori, c_op_xori: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.writereg = w_rt;
                case (w_op)
                    c_op_slti: o_ctrl.aluctrl = c_alu_slt;
                    c_op_andi: o_ctrl.aluctrl = c_alu_and;
                    c_op_ori:  o_ctrl.aluctrl = c_alu_or;
                    c_op_xori: o_ctrl.aluctrl = c_alu_xor;
                    default:   o_ctrl.aluctrl = c_alu_add;
                endcase
            end
            c_op_lw, c_op_lh, c_op_lb: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.aluctrl  = c_alu_add;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.memtoreg = 1'b1;
                o_ctrl.writereg = w_rt;
                o_ctrl.memread  = (w_op == c_op_lw) ? c_sz_word :
                                  (w_op == c_op_lh) ? c_sz_half : c_sz_byte;
            end
            c_op_sw, c_op_sh, c_op_sb: begin
                o_uses_rt       = 1'b1;
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.aluctrl  = c_alu_add;
                o_ctrl.writereg = w_rt;
                o_ctrl.memwrite = (w_op == c_op_sw) ? c_sz_word :
                                  (w_op == c_op_sh) ? c_sz_half : c_sz_byte;
            end
            c_op_beq: begin
                o_uses_rt      = 1'b1;
                o_ctrl.aluctrl = c_alu_beq;
            end
            c_op_bne: begin
                o_uses_rt      = 1'b1;
                o_ctrl.aluctrl = c_alu_bne;
            end
            c_op_blez: o_ctrl.aluctrl = c_alu_blez;
            c_op_bgtz: o_ctrl.aluctrl = c_alu_bgtz;
            c_op_regimm: begin
                // rt selects the subtype; any other rt value is treated as unknown
                if (w_rt == 5'b00001) begin
                    o_ctrl.aluctrl = c_alu_bgez;
                end else if (w_rt == 5'b00000) begin
                    o_ctrl.aluctrl = c_alu_bltz;
                end
            end
            c_op_j: o_jump = 1'b1;
            c_op_jal: begin
                o_jump          = 1'b1;
                o_ctrl.regwrite = 1'b1;
                o_ctrl.jal      = 1'b1;
                o_ctrl.writereg = 5'd31;
            end
            default: o_ctrl = c_bubble;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_controller
// Purpose  : Pipelined control unit: decode, ID/EX-EX/MEM-MEM/WB control
//            registers, load-use stall, multi-cycle mul hold, flushes.
// Revision : 1.0
// ============================================================================
module pipelined_controller
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 5,
    parameter int REG_ADDR_W  = 5,
    parameter int MUL_LATENCY = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    pipelined_controller_if.slave bus
);

    localparam logic [2:0] c_mul_hold = 3'(MUL_LATENCY - 1);

    ctrl_t      w_dec;
    logic       w_jump;
    logic       w_jr;
    logic       w_uses_rt;
    logic       w_is_mul;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_hold;
    logic       w_load_use;
    logic       w_pc_write;
    logic       w_ifid_write;
    logic       w_flush;
    logic       w_unused;

    ctrl_t      r_ex;
    ctrl_t      r_mem;
    ctrl_t      r_wb;
    logic [2:0] r_cnt;

    ctrl_decode u_decode (
        .i_instr   (bus.Instruction),
        .o_ctrl    (w_dec),
        .o_jump    (w_jump),
        .o_jr      (w_jr),
        .o_uses_rt (w_uses_rt),
        .o_is_mul  (w_is_mul)
    );

    assign w_rs   = bus.Instruction[25:21];
    assign w_rt   = bus.Instruction[20:16];
    assign w_hold = (r_cnt != 3'd0);

    assign w_load_use = (r_ex.memread != c_sz_none) && (r_ex.writereg != '0) &&
                        ((r_ex.writereg == w_rs) || (w_uses_rt && (r_ex.writereg == w_rt)));

    // Priority: taken branch, mul hold, load-use stall, jump flush
    always_comb begin
        w_pc_write   = 1'b1;
        w_ifid_write = 1'b1;
        w_flush      = 1'b0;
        if (!Rst) begin
            w_flush = 1'b0;
        end else if (bus.BranchTaken) begin
            w_flush = 1'b1;
        end else if (w_hold || w_load_use) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
        end else begin
            w_flush = w_jump | w_jr;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_ex  <= c_bubble;
            r_mem <= c_bubble;
            r_wb  <= c_bubble;
            r_cnt <= 3'd0;
        end else begin
            r_wb <= r_mem;
            if (bus.BranchTaken) begin
                r_mem <= r_ex;
                r_ex  <= c_bubble;
            end else if (w_hold) begin
                // mul stays in EX; downstream sees bubbles until it is done
                r_mem <= c_bubble;
                r_cnt <= r_cnt - 3'd1;
            end else if (w_load_use) begin
                r_mem <= r_ex;
                r_ex  <= c_bubble;
            end else begin
                r_mem <= r_ex;
                r_ex  <= w_dec;
                if (w_is_mul) begin
                    r_cnt <= c_mul_hold;
                end
            end
        end
    end

    assign w_unused = ^{r_wb.alusrc, r_wb.regdst, r_wb.shift, r_wb.aluctrl,
                        r_wb.memwrite, r_wb.memread};

    assign bus.PCWrite         = w_pc_write;
    assign bus.IFIDWrite       = w_ifid_write;
    assign bus.IFIDFlush       = w_flush;
    assign bus.Jump            = w_jump;
    assign bus.Jr              = w_jr;
    assign bus.EX_ALUSrc       = r_ex.alusrc;
    assign bus.EX_RegDst       = r_ex.regdst;
    assign bus.EX_ShiftControl = r_ex.shift;
    assign bus.EX_ALUControl   = ALU_CTRL_W'(r_ex.aluctrl);
    assign bus.MEM_MemWrite    = r_mem.memwrite;
    assign bus.MEM_MemRead     = r_mem.memread;
    assign bus.WB_RegWrite     = r_wb.regwrite;
    assign bus.WB_MemToReg     = r_wb.memtoreg;
    assign bus.WB_Jal          = r_wb.jal;
    assign bus.WB_WriteReg     = REG_ADDR_W'(r_wb.writereg);

endmodule
`default_nettype wire

// File: tb/tb_pipelined_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_controller
// Purpose  : Directed + random bench with a mnemonic-level pipeline model.
// Revision : 1.0
// ============================================================================
module tb_pipelined_controller;

    localparam int LAT = 4;

    typedef enum int {
        K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_NOR, K_SLT, K_SLL, K_SRL, K_MUL, K_JR,
        K_ADDI, K_ANDI, K_ORI, K_XORI, K_SLTI, K_LW, K_LH, K_LB, K_SW, K_SH, K_SB,
        K_BEQ, K_BNE, K_BLEZ, K_BGTZ, K_BGEZ, K_BLTZ, K_J, K_JAL, K_BAD
    } kind_e;

    typedef enum int {C_R, C_SH, C_MUL, C_JR, C_IMM, C_LD, C_ST, C_BR, C_J, C_JAL, C_BAD} cat_e;

    typedef struct {
        logic [31:0] instr;
        logic        alusrc, regdst, shift;
        logic [4:0]  alu;
        logic [1:0]  mw, mr;
        logic        rw, m2r, jal;
        logic [4:0]  wr;
        logic        jump, jr, uses_rt, is_mul, is_branch;
        logic [4:0]  rs, rt;
    } rec_t;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    pipelined_controller_if #(.ALU_CTRL_W(5), .REG_ADDR_W(5)) bus ();

    pipelined_controller #(.ALU_CTRL_W(5), .REG_ADDR_W(5), .MUL_LATENCY(LAT)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int   vectors = 0;
    int   miscompares = 0;
    rec_t q[$];
    rec_t id, m_ex, m_mem, m_wb, zero_rec, nop;
    int   m_cnt;

    // Expected behaviour is written per mnemonic, not derived from bit fields
    function automatic rec_t gen(kind_e k, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        rec_t r;
        cat_e c;
        logic [5:0] op, fn;
        logic [4:0] alu, rt_f;
        logic [1:0] sz;
        logic       rtuse;
        logic [15:0] imm;
        logic [25:0] tgt;
        r = '{default: '0};
        c = C_BAD; op = '0; fn = '0; alu = '0; sz = '0; rt_f = rt; rtuse = 1'b0;
        imm = 16'($urandom);
        tgt = 26'($urandom);
        case (k)
            K_ADD:  begin c = C_R;  fn = 6'h20; alu = 5'd1;  end
            K_SUB:  begin c = C_R;  fn = 6'h22; alu = 5'd2;  end
            K_AND:  begin c = C_R;  fn = 6'h24; alu = 5'd6;  end
            K_OR:   begin c = C_R;  fn = 6'h25; alu = 5'd7;  end
            K_XOR:  begin c = C_R;  fn = 6'h26; alu = 5'd8;  end
            K_NOR:  begin c = C_R;  fn = 6'h27; alu = 5'd13; end
            K_SLT:  begin c = C_R;  fn = 6'h2A; alu = 5'd14; end
            K_SLL:  begin c = C_SH; fn = 6'h00; alu = 5'd4;  end
            K_SRL:  begin c = C_SH; fn = 6'h02; alu = 5'd5;  end
            K_MUL:  c = C_MUL;
            K_JR:   c = C_JR;
            K_ADDI: begin c = C_IMM; op = 6'h08; alu = 5'd1;  end
            K_ANDI: begin c = C_IMM; op = 6'h0C; alu = 5'd6;  end
            K_ORI:  begin c = C_IMM; op = 6'h0D; alu = 5'd7;  end
            K_XORI: begin c = C_IMM; op = 6'h0E; alu = 5'd8;  end
            K_SLTI: begin c = C_IMM; op = 6'h0A; alu = 5'd14; end
            K_LW:   begin c = C_LD; op = 6'h23; sz = 2'b01; end
            K_LH:   begin c = C_LD; op = 6'h21; sz = 2'b10; end
            K_LB:   begin c = C_LD; op = 6'h20; sz = 2'b11; end
            K_SW:   begin c = C_ST; op = 6'h2B; sz = 2'b01; end
            K_SH:   begin c = C_ST; op = 6'h29; sz = 2'b10; end
            K_SB:   begin c = C_ST; op = 6'h28; sz = 2'b11; end
            K_BEQ:  begin c = C_BR; op = 6'h04; alu = 5'd12; rtuse = 1'b1; end
            K_BNE:  begin c = C_BR; op = 6'h05; alu = 5'd15; rtuse = 1'b1; end
            K_BLEZ: begin c = C_BR; op = 6'h06; alu = 5'd17; end
            K_BGTZ: begin c = C_BR; op = 6'h07; alu = 5'd16; end
            K_BGEZ: begin c = C_BR; op = 6'h01; alu = 5'd11; rt_f = 5'd1; end
            K_BLTZ: begin c = C_BR; op = 6'h01; alu = 5'd18; rt_f = 5'd0; end
            K_J:    c = C_J;
            K_JAL:  c = C_JAL;
            default: c = C_BAD;
        endcase
        case (c)
            C_R, C_SH: begin
                r.instr = {6'h00, rs, rt, rd, 5'd0, fn};
                r.regdst = 1'b1; r.rw = 1'b1; r.wr = rd; r.alu = alu;
                r.shift = (c == C_SH); r.uses_rt = 1'b1;
            end
            C_MUL: begin
                r.instr = {6'h1C, rs, rt, rd, 5'd0, 6'h02};
                r.regdst = 1'b1; r.rw = 1'b1; r.wr = rd; r.alu = 5'd3;
                r.is_mul = 1'b1; r.uses_rt = 1'b1;
            end
            C_JR: begin
                r.instr = {6'h00, rs, 15'd0, 6'h08};
                r.jr = 1'b1; r.uses_rt = 1'b1;
            end
            C_IMM: begin
                r.instr = {op, rs, rt, imm};
                r.alusrc = 1'b1; r.rw = 1'b1; r.wr = rt; r.alu = alu;
            end
            C_LD: begin
                r.instr = {op, rs, rt, imm};
                r.alusrc = 1'b1; r.alu = 5'd1; r.rw = 1'b1; r.m2r = 1'b1; r.wr = rt; r.mr = sz;
            end
            C_ST: begin
                r.instr = {op, rs, rt, imm};
                r.alusrc = 1'b1; r.alu = 5'd1; r.mw = sz; r.wr = rt; r.uses_rt = 1'b1;
            end
            C_BR: begin
                r.instr = {op, rs, rt_f, imm};
                r.alu = alu; r.is_branch = 1'b1; r.uses_rt = rtuse;
            end
            C_J:   begin r.instr = {6'h02, tgt}; r.jump = 1'b1; end
            C_JAL: begin
                r.instr = {6'h03, tgt};
                r.jump = 1'b1; r.rw = 1'b1; r.jal = 1'b1; r.wr = 5'd31;
            end
            default: r.instr = {6'h3F, tgt};
        endcase
        r.rs = r.instr[25:21];
        r.rt = r.instr[20:16];
        return r;
    endfunction

    function automatic rec_t fetch();
        if (q.size() == 0) return nop;
        return q.pop_front();
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One ID cycle: drive at negedge, compare, then advance the model at posedge
    task automatic step(input logic rst_n, input logic bt);
        logic lu, e_pcw, e_ifw, e_fl;
        @(negedge Clk);
        Rst = rst_n;
        bus.Instruction = id.instr;
        bus.BranchTaken = bt;
        #1;
        lu = (m_ex.mr != 2'b00) && (m_ex.wr != 5'd0) &&
             ((m_ex.wr == id.rs) || (id.uses_rt && (m_ex.wr == id.rt)));
        if (!rst_n)                 begin e_pcw = 1'b1; e_ifw = 1'b1; e_fl = 1'b0; end
        else if (bt)                begin e_pcw = 1'b1; e_ifw = 1'b1; e_fl = 1'b1; end
        else if (m_cnt > 0 || lu)   begin e_pcw = 1'b0; e_ifw = 1'b0; e_fl = 1'b0; end
        else                        begin e_pcw = 1'b1; e_ifw = 1'b1; e_fl = id.jump | id.jr; end
        chk("PCWrite",   32'(bus.PCWrite),   32'(e_pcw));
        chk("IFIDWrite", 32'(bus.IFIDWrite), 32'(e_ifw));
        chk("IFIDFlush", 32'(bus.IFIDFlush), 32'(e_fl));
        chk("Jump",      32'(bus.Jump),      32'(id.jump));
        chk("Jr",        32'(bus.Jr),        32'(id.jr));
        chk("EX_ALUSrc",       32'(bus.EX_ALUSrc),       32'(m_ex.alusrc));
        chk("EX_RegDst",       32'(bus.EX_RegDst),       32'(m_ex.regdst));
        chk("EX_ShiftControl", 32'(bus.EX_ShiftControl), 32'(m_ex.shift));
        chk("EX_ALUControl",   32'(bus.EX_ALUControl),   32'(m_ex.alu));
        chk("MEM_MemWrite",    32'(bus.MEM_MemWrite),    32'(m_mem.mw));
        chk("MEM_MemRead",     32'(bus.MEM_MemRead),     32'(m_mem.mr));
        chk("WB_RegWrite",     32'(bus.WB_RegWrite),     32'(m_wb.rw));
        chk("WB_MemToReg",     32'(bus.WB_MemToReg),     32'(m_wb.m2r));
        chk("WB_Jal",          32'(bus.WB_Jal),          32'(m_wb.jal));
        chk("WB_WriteReg",     32'(bus.WB_WriteReg),     32'(m_wb.wr));
        @(posedge Clk);
        if (!rst_n) begin
            m_ex = zero_rec; m_mem = zero_rec; m_wb = zero_rec; m_cnt = 0;
            id = fetch();
        end else begin
            m_wb = m_mem;
            if (bt) begin
                m_mem = m_ex; m_ex = zero_rec; id = nop;
            end else if (m_cnt > 0) begin
                m_mem = zero_rec; m_cnt--;
            end else if (lu) begin
                m_mem = m_ex; m_ex = zero_rec;
            end else begin
                m_mem = m_ex; m_ex = id;
                if (id.is_mul) m_cnt = LAT - 1;
                id = (id.jump || id.jr) ? nop : fetch();
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    initial begin
        zero_rec = '{default: '0};
        nop      = gen(K_SLL, 5'd0, 5'd0, 5'd0);
        m_ex = zero_rec; m_mem = zero_rec; m_wb = zero_rec; m_cnt = 0;
        id = nop;
        bus.Instruction = 32'd0;
        bus.BranchTaken = 1'b0;
        repeat (2) @(posedge Clk);

        // reset, then add $3,$1,$2 with literal spot checks
        q.push_back(gen(K_ADD, 5'd1, 5'd2, 5'd3));
        step(1'b0, 1'b0);
        chk("add_encoding_in_id", id.instr, 32'h0022_1820);
        step(1'b1, 1'b0);
        #1;
        chk("add_ex_alu", 32'(bus.EX_ALUControl), 32'h01);
        chk("add_ex_regdst", 32'(bus.EX_RegDst), 32'h1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        #1;
        chk("add_wb_regwrite", 32'(bus.WB_RegWrite), 32'h1);
        chk("add_wb_writereg", 32'(bus.WB_WriteReg), 32'd3);
        run(2);

        // lw $2,0($1) ; add $4,$2,$5  -> one stall cycle
        q.push_back(gen(K_LW, 5'd1, 5'd2, 5'd0));
        q.push_back(gen(K_ADD, 5'd2, 5'd5, 5'd4));
        run(7);

        // mul $3,$1,$2 held for LAT cycles
        q.push_back(gen(K_MUL, 5'd1, 5'd2, 5'd3));
        run(9);

        // beq taken with add in ID
        q.push_back(gen(K_BEQ, 5'd1, 5'd2, 5'd0));
        q.push_back(gen(K_ADD, 5'd1, 5'd2, 5'd6));
        run(2);
        step(1'b1, 1'b1);
        run(4);

        // taken branch coinciding with a load-use condition
        q.push_back(gen(K_LW, 5'd1, 5'd2, 5'd0));
        q.push_back(gen(K_ADD, 5'd2, 5'd5, 5'd4));
        run(2);
        step(1'b1, 1'b1);
        run(4);

        // j, unknown opcode, mul interrupted by reset
        q.push_back(gen(K_J, 5'd0, 5'd0, 5'd0));
        q.push_back(gen(K_BAD, 5'd0, 5'd0, 5'd0));
        q.push_back(gen(K_MUL, 5'd1, 5'd2, 5'd3));
        run(6);
        step(1'b0, 1'b0);
        run(5);

        // reset while a load-use stall is pending
        q.push_back(gen(K_LW, 5'd1, 5'd2, 5'd0));
        q.push_back(gen(K_ADD, 5'd2, 5'd5, 5'd4));
        run(2);
        step(1'b0, 1'b0);
        run(5);

        // randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 500; i++) begin
            logic bt, rn;
            if (q.size() < 2) begin
                q.push_back(gen(kind_e'($urandom_range(0, int'(K_BAD))),
                                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                5'($urandom_range(0, 3))));
            end
            rn = ($urandom_range(0, 63) != 0);
            bt = rn && m_ex.is_branch && ($urandom_range(0, 1) == 1);
            step(rn, bt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_controller.md
# pipelined_controller

Control unit for the five-stage pipelined MIPS datapath. It decodes the instruction held in IF/ID and carries the control bundle through its own ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards, holds the pipeline for multi-cycle `mul`, and flushes on taken branches and jumps. It sits beside the datapath's stage registers and replaces per-cycle combinational decode for the pipelined core.

## Interface
Parameters:
- `ALU_CTRL_W`, 5: ALU control width.
- `REG_ADDR_W`, 5: register index width.
- `MUL_LATENCY`, 1: cycles `mul` occupies EX. Legal range 1–8.

Ports:
- `Clk` in 1: single clock; all state updates on its rising edge.
- `Rst` in 1: reset is synchronous and active-low.
- `Instruction` in 32: IF/ID instruction (ID stage).
- `BranchTaken` in 1: branch resolved taken in EX (from datapath comparator).
- `PCWrite` out 1: PC update enable.
- `IFIDWrite` out 1: IF/ID load enable.
- `IFIDFlush` out 1: clear IF/ID to NOP on next edge.
- `Jump`, `Jr` out 1 each: ID-stage PC select.
- `EX_ALUSrc`, `EX_RegDst`, `EX_ShiftControl` out 1 each.
- `EX_ALUControl` out `ALU_CTRL_W`.
- `MEM_MemWrite`, `MEM_MemRead` out 2 each: 00 none, 01 word, 10 half, 11 byte.
- `WB_RegWrite`, `WB_MemToReg`, `WB_Jal` out 1 each.
- `WB_WriteReg` out `REG_ADDR_W`: destination register index.

## Operation
- **Decode (ID, combinational):**
  - R-type: dest = rd. `jr` raises `Jr` and writes nothing.
  - `mul` (op 011100): R-format.
  - Loads, stores, immediates: dest = rt.
  - `jal`: dest = 31, `WB_Jal` = 1.
  - `j`: `Jump` = 1.
  - Branches: no writeback.
  - Unknown opcode or funct decodes to an all-zero bundle (NOP). Don't-care fields are driven as 0, never X.
- **ALUControl codes:** add 00001, sub 00010, mul 00011, sll 00100, srl 00101, and 00110, or 00111, xor 01000, bgez 01011, beq 01100, nor 01101, slt 01110, bne 01111, bgtz 10000, blez 10001, bltz 10010.
- **Shifts:** sll/srl set `ShiftControl`.
- **Loads/stores:** address via add.
- **Branch subtype:** op 000001 uses rt to pick bgez (00001) or bltz (00000).
- **Load-use stall:** raised when EX `MemRead` != 00, EX dest != 0, and EX dest equals ID rs, or equals ID rt for R-type, store, beq or bne. Effects: `PCWrite` = 0, `IFIDWrite` = 0, bubble into ID/EX, EX/MEM advances normally.
- **mul hold:** a down-counter loads `MUL_LATENCY`−1 when `mul` enters EX. While the counter is nonzero:
  - `PCWrite`, `IFIDWrite` = 0.
  - ID/EX holds its value.
  - EX/MEM receives a bubble.
  - With `MUL_LATENCY` = 1, no hold is applied.
- **Flush:**
  - `BranchTaken` = 1: `IFIDFlush` = 1 and a bubble into ID/EX on the same edge.
  - ID `Jump` or `Jr`: `IFIDFlush` = 1, and the jump itself proceeds into ID/EX.
- **Priority (highest first):** `BranchTaken`, mul hold, load-use stall, jump flush.
  - A branch and a mul are never in EX together.
  - A stall suppresses a same-cycle jump flush; the jump re-decodes after the stall.

## Timing
- ID outputs (`Jump`, `Jr`, `IFIDFlush`, `PCWrite`, `IFIDWrite`) are combinational from `Instruction`, the stage registers and the counter.
- Stage outputs are registered. A bundle decoded in cycle n appears on `EX_*` in n+1, `MEM_*` in n+2 and `WB_*` in n+3, plus hold cycles.
- Load-use stall inserts exactly 1 bubble. mul inserts `MUL_LATENCY`−1 bubbles.
- **Reset** (`Rst` low at an edge):
  - All stage registers and the counter clear to 0, so every `EX_*`, `MEM_*`, `WB_*` output is 0.
  - While `Rst` is low, `PCWrite` = 1, `IFIDWrite` = 1 and `IFIDFlush` = 0.
  - Reset mid-hold abandons the mul; reset mid-stall drops the bubble.
- `BranchTaken` is sampled only in the cycle it is asserted. It must not be asserted while EX holds a bubble.

## Structure
- **`ctrl_pkg`:** opcode and funct localparams, ALUControl codes, MemRead/MemWrite size codes, and a packed control-bundle struct with fields alusrc, regdst, shift, aluctrl, memwrite, memread, regwrite, memtoreg, jal, writereg.
- **`ctrl_decode`:** combinational sub-module mapping instruction to bundle. It is instantiated once; its bubble value is the all-zero bundle.
- **Top level:** stage registers, hazard logic and the mul counter.

## Test plan
- **Reset, then add $3,$1,$2:** add is 0x00221820.
  - Cycle +1: `EX_ALUControl` = 00001, `EX_RegDst` = 1.
  - Cycle +3: `WB_RegWrite` = 1, `WB_WriteReg` = 3.
- **lw $2,0($1) then add $4,$2,$5:** expect 1 cycle with `PCWrite` = 0 and `IFIDWrite` = 0, then `EX_*` all 0 for one cycle. The add reaches EX one cycle late.
- **mul $3,$1,$2 with `MUL_LATENCY` = 4:** `PCWrite` = 0 for 3 cycles. `EX_ALUControl` stays 00011 for 4 cycles, `MEM_*` shows 3 bubbles, then a single mul writeback.
- **beq with `BranchTaken` = 1 while an add sits in ID:** `IFIDFlush` = 1, and the add never reaches EX (next `EX_*` all 0). Also cover `BranchTaken` together with a load-use condition: the flush wins and `PCWrite` = 1.
- **j, then unknown opcode 0x3F, then `Rst` low during a mul hold:**
  - j: `Jump` = 1 and `IFIDFlush` = 1.
  - Unknown opcode: all-zero bundle.
  - Reset: counter = 0 and all stage outputs 0 on the next edge.
